// File: rtl/bas_game_ctrl_pkg.sv
// Shared state encodings and default game parameters
// for the basketball scoreboard game-flow sequencer.
package bas_game_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_PAUSE     = 3'd2,
    S_SHOT_VIOL = 3'd3,
    S_QTR_END   = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam int QUARTERS_DEF   = 4;
  localparam int BUZZ_TICKS_DEF = 3;

endpackage

// File: rtl/bas_game_ctrl_key_edge.sv
// Registered rising-edge detector for one debounced key.
// A key held through reset yields no edge afterwards.
module bas_key_edge (
  input  logic CLOCK,
  input  logic RST,
  input  logic i_key,
  output logic o_edge
);

  logic r_prev;
  logic r_edge;

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_prev <= 1'b1;
      r_edge <= 1'b0;
    end else begin
      r_prev <= i_key;
      r_edge <= i_key & ~r_prev;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/bas_game_ctrl.sv
// Game-flow FSM: drives clock enables, reload pulses,
// quarter count and buzzer for the scoreboard counters.
module bas_game_ctrl
  import bas_game_ctrl_pkg::*;
#(
  parameter int QUARTERS   = QUARTERS_DEF,
  parameter int BUZZ_TICKS = BUZZ_TICKS_DEF
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       tick_1hz,
  input  logic       key_start,
  input  logic       key_shot,
  input  logic       shot_zero,
  input  logic       game_zero,
  output logic       run_shot,
  output logic       run_game,
  output logic       shot_load,
  output logic       game_load,
  output logic [2:0] quarter,
  output logic       buzzer,
  output logic       game_over
);

  localparam logic [3:0] LP_BUZZ = 4'(BUZZ_TICKS);
  localparam logic [2:0] LP_QTR  = 3'(QUARTERS);

  logic       w_start_edge;
  logic       w_shot_edge;
  logic [3:0] w_buzz_nxt;
  logic       w_buzz_done;

  state_t     r_state;
  logic [3:0] r_buzz;
  logic [2:0] r_quarter;
  logic       r_shot_load;
  logic       r_game_load;

  bas_key_edge u_start_edge (
    .CLOCK  (CLOCK),
    .RST    (RST),
    .i_key  (key_start),
    .o_edge (w_start_edge)
  );

  bas_key_edge u_shot_edge (
    .CLOCK  (CLOCK),
    .RST    (RST),
    .i_key  (key_shot),
    .o_edge (w_shot_edge)
  );

  assign w_buzz_nxt  = r_buzz + 4'd1;
  assign w_buzz_done = tick_1hz &&
                       (w_buzz_nxt == LP_BUZZ);

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_buzz      <= 4'd0;
      r_quarter   <= 3'd1;
      r_shot_load <= 1'b0;
      r_game_load <= 1'b0;
    end else begin
      r_shot_load <= 1'b0;
      r_game_load <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state     <= S_RUN;
            r_shot_load <= 1'b1;
            r_game_load <= 1'b1;
          end
        end
        S_RUN: begin
          // manual reload beats a same-cycle shot_zero
          r_shot_load <= w_shot_edge;
          if (game_zero) begin
            r_state <= S_QTR_END;
            r_buzz  <= 4'd0;
          end else if (shot_zero && !w_shot_edge) begin
            r_state <= S_SHOT_VIOL;
            r_buzz  <= 4'd0;
          end else if (w_start_edge) begin
            r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          r_shot_load <= w_shot_edge;
          if (w_start_edge) begin
            r_state <= S_RUN;
          end
        end
        S_SHOT_VIOL: begin
          if (tick_1hz) begin
            r_buzz <= w_buzz_nxt;
          end
          if (w_buzz_done) begin
            r_state     <= S_PAUSE;
            r_shot_load <= 1'b1;
          end
        end
        S_QTR_END: begin
          if (tick_1hz) begin
            r_buzz <= w_buzz_nxt;
          end
          if (w_buzz_done) begin
            if (r_quarter == LP_QTR) begin
              r_state <= S_GAME_OVER;
            end else begin
              r_state     <= S_PAUSE;
              r_quarter   <= r_quarter + 3'd1;
              r_shot_load <= 1'b1;
              r_game_load <= 1'b1;
            end
          end
        end
        S_GAME_OVER: begin
          r_state <= S_GAME_OVER;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign run_shot  = (r_state == S_RUN);
  assign run_game  = (r_state == S_RUN);
  assign buzzer    = (r_state == S_SHOT_VIOL) ||
                     (r_state == S_QTR_END);
  assign game_over = (r_state == S_GAME_OVER);
  assign shot_load = r_shot_load;
  assign game_load = r_game_load;
  assign quarter   = r_quarter;

endmodule
